match_feeder: RTL and testbench
===============================

MATCH_FEEDER -- requirements
Module: match_feeder

Interface
REQ-001 SHALL have parameter HD_THRESH, default 8'd64, the maximum Hamming distance accepted as a match when MATCH_THRESH_EN is defined.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse that begins a matching run; ignored while busy.
REQ-005 num_main  input  10  Main keypoint count, latched on accepted start.
REQ-006 num_slave  input  10  Slave keypoint count, latched on accepted start.
REQ-007 main_addr  output  10  Main descriptor memory address.
REQ-008 main_rdata  input  148  {coor[19:0], des[127:0]}, valid one cycle after main_addr.
REQ-009 slave_addr  output  10  Slave descriptor memory address.
REQ-010 slave_rdata  input  148  {coor, des}, valid one cycle after slave_addr.
REQ-011 core_clear  output  1  clear pulse to the matcher core.
REQ-012 core_en  output  1  Slave-valid strobe to the matcher core.
REQ-013 core_main  output  148  registered current Main word, held stable through a pass.
REQ-014 core_slave  output  148  Slave word, aligned with core_en.
REQ-015 core_index  input  10  best Slave index from the core.
REQ-016 core_coor  input  20  best Slave coordinate from the core.
REQ-017 core_min_hd  input  8  best distance from the core.
REQ-018 core_done  input  1  one-cycle end-of-pass pulse from the core.
REQ-019 res_valid  output  1  result available.
REQ-020 res_ready  input  1  consumer accepts result when high with res_valid.
REQ-021 res_data  output  68  {main_idx[9:0], main_coor[19:0], slave_idx[9:0], slave_coor[19:0], hd[7:0]}.
REQ-022 busy  output  1  high from accepted start until return to IDLE.

Function
REQ-023 FSM states SHALL be IDLE, LOAD_MAIN, CLEAR, STREAM, WAIT_DONE, OUTPUT.
REQ-024 IDLE->LOAD_MAIN on start with num_main!=0 and num_slave!=0; otherwise the start SHALL be dropped: busy stays low and no result is produced.
REQ-025 LOAD_MAIN SHALL drive main_addr=m for one cycle; CLEAR SHALL latch main_rdata into core_main and assert core_clear for exactly one cycle.
REQ-026 STREAM SHALL issue slave_addr 0..num_slave-1 on consecutive cycles; core_en SHALL be high for exactly num_slave contiguous cycles, one cycle after each address, with core_slave=slave_rdata.
REQ-027 The first core_en SHALL occur at least one cycle after core_clear; core_main SHALL not change between core_clear and core_done.
REQ-028 WAIT_DONE SHALL wait for core_done, then capture {m, core_main[147:128], core_index, core_coor, core_min_hd} into res_data.
REQ-029 OUTPUT SHALL hold res_valid and res_data stable until res_valid&&res_ready; then m increments, giving LOAD_MAIN if m<num_main, else IDLE.
REQ-030 Run latency per Main word SHALL be num_slave+8 cycles excluding backpressure; start to first core_clear SHALL be 2 cycles.
REQ-031 Counters SHALL be 10-bit with terminal compare at count-1, with no wrap; num=1023 SHALL process 1023 items.

Reset
REQ-032 When rst_n is low, the FSM SHALL go to IDLE and busy, res_valid, core_en, core_clear SHALL be 0, addresses 0, res_data and core_main/core_slave 0; reset mid-run SHALL abandon the run with no result.

Configuration
REQ-033 With MATCH_THRESH_EN defined, a captured result with hd>HD_THRESH SHALL be discarded (no res_valid) and the run SHALL advance to the next Main; without the macro, every Main produces exactly one result.

Structure
REQ-034 Widths (ADDR_W=10, COOR_W=20, DES_W=128, HD_W=8), the 68-bit result field offsets and the FSM state enum SHALL live in shared package match_pkg; no sub-module is required, and match_core is instantiated beside this block by the parent.

Verification
REQ-035 num_main=3, num_slave=5, res_ready=1 -> 3 results, main_idx 0,1,2; 5-cycle core_en bursts; busy falls after the third handshake.
REQ-036 Slave 3 identical to Main 0 -> result 0 has slave_idx=3, hd=0, slave_coor=slave word 3 [147:128].
REQ-037 res_ready held low for 20 cycles -> res_valid and res_data stable; no further core_clear until the handshake.
REQ-038 num_slave=0 or num_main=0 at start -> busy stays 0, no core_en, no result; start pulsed while busy -> ignored.
REQ-039 rst_n low mid-STREAM -> core_en=0 and busy=0 immediately; the next start runs cleanly from Main 0.
REQ-040 MATCH_THRESH_EN, HD_THRESH=10, hds {5,40,10} -> 2 results (main_idx 0 and 2).

Source files
------------

// File: rtl/match_pkg.sv
// Shared widths, result-field layout and FSM state encoding for match_feeder.
package match_pkg;

   localparam int ADDR_W = 10;
   localparam int COOR_W = 20;
   localparam int DES_W  = 128;
   localparam int HD_W   = 8;
   localparam int WORD_W = COOR_W + DES_W;
   localparam int RES_W  = 2 * ADDR_W + 2 * COOR_W + HD_W;

   // res_data = {main_idx, main_coor, slave_idx, slave_coor, hd}
   localparam int RES_HD_LSB    = 0;
   localparam int RES_SCOOR_LSB = RES_HD_LSB + HD_W;
   localparam int RES_SIDX_LSB  = RES_SCOOR_LSB + COOR_W;
   localparam int RES_MCOOR_LSB = RES_SIDX_LSB + ADDR_W;
   localparam int RES_MIDX_LSB  = RES_MCOOR_LSB + COOR_W;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_MAIN,
      CLEAR,
      STREAM,
      WAIT_DONE,
      OUTPUT
   } feeder_state_t;

   function automatic logic [RES_W-1:0] pack_result(
      input logic [ADDR_W-1:0] main_idx,
      input logic [COOR_W-1:0] main_coor,
      input logic [ADDR_W-1:0] slave_idx,
      input logic [COOR_W-1:0] slave_coor,
      input logic [HD_W-1:0]   hd
   );
      logic [RES_W-1:0] r;
      r = '0;
      r[RES_MIDX_LSB  +: ADDR_W] = main_idx;
      r[RES_MCOOR_LSB +: COOR_W] = main_coor;
      r[RES_SIDX_LSB  +: ADDR_W] = slave_idx;
      r[RES_SCOOR_LSB +: COOR_W] = slave_coor;
      r[RES_HD_LSB    +: HD_W]   = hd;
      return r;
   endfunction

endpackage

// File: rtl/match_feeder.sv
// Feeds Main/Slave descriptors to the external matcher core and returns one result per Main.
// Optional MATCH_THRESH_EN: results whose distance exceeds HD_THRESH are discarded.
module match_feeder
   import match_pkg::*;
#(
   parameter logic [HD_W-1:0] HD_THRESH = 8'd64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   num_main,
   input  logic [ADDR_W-1:0]   num_slave,
   output logic [ADDR_W-1:0]   main_addr,
   input  logic [WORD_W-1:0]   main_rdata,
   output logic [ADDR_W-1:0]   slave_addr,
   input  logic [WORD_W-1:0]   slave_rdata,
   output logic                core_clear,
   output logic                core_en,
   output logic [WORD_W-1:0]   core_main,
   output logic [WORD_W-1:0]   core_slave,
   input  logic [ADDR_W-1:0]   core_index,
   input  logic [COOR_W-1:0]   core_coor,
   input  logic [HD_W-1:0]     core_min_hd,
   input  logic                core_done,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [RES_W-1:0]    res_data,
   output logic                busy
);

   feeder_state_t     state;
   logic [ADDR_W-1:0] nm_q;
   logic [ADDR_W-1:0] ns_q;
   logic [ADDR_W-1:0] m_cnt;
   logic              last_main;
   logic              last_slave;
   logic              drop;

   assign last_main  = (m_cnt == nm_q - ADDR_W'(1));
   assign last_slave = (slave_addr == ns_q - ADDR_W'(1));

   // Slave memory answers one cycle after slave_addr, exactly when core_en is high.
   assign core_slave = core_en ? slave_rdata : '0;

`ifdef MATCH_THRESH_EN
   assign drop = (core_min_hd > HD_THRESH);
`else
   assign drop = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         nm_q       <= '0;
         ns_q       <= '0;
         m_cnt      <= '0;
         main_addr  <= '0;
         slave_addr <= '0;
         core_clear <= 1'b0;
         core_en    <= 1'b0;
         core_main  <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         busy       <= 1'b0;
      end else begin
         core_clear <= (state == CLEAR);
         core_en    <= (state == STREAM);

         case (state)
            IDLE: begin
               if (start && (num_main != '0) && (num_slave != '0)) begin
                  nm_q      <= num_main;
                  ns_q      <= num_slave;
                  m_cnt     <= '0;
                  main_addr <= '0;
                  busy      <= 1'b1;
                  state     <= LOAD_MAIN;
               end
            end

            LOAD_MAIN: state <= CLEAR;

            CLEAR: begin
               core_main  <= main_rdata;
               slave_addr <= '0;
               state      <= STREAM;
            end

            STREAM: begin
               if (last_slave) begin
                  state <= WAIT_DONE;
               end else begin
                  slave_addr <= slave_addr + ADDR_W'(1);
               end
            end

            WAIT_DONE: begin
               if (core_done) begin
                  if (!drop) begin
                     res_data  <= pack_result(m_cnt, core_main[WORD_W-1:DES_W],
                                              core_index, core_coor, core_min_hd);
                     res_valid <= 1'b1;
                     state     <= OUTPUT;
                  end else if (last_main) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     m_cnt     <= m_cnt + ADDR_W'(1);
                     main_addr <= m_cnt + ADDR_W'(1);
                     state     <= LOAD_MAIN;
                  end
               end
            end

            OUTPUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (last_main) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     m_cnt     <= m_cnt + ADDR_W'(1);
                     main_addr <= m_cnt + ADDR_W'(1);
                     state     <= LOAD_MAIN;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_match_feeder.sv
// Directed bench for match_feeder with synchronous-read memories and a behavioural matcher core.
// Build with MATCH_THRESH_EN to exercise the threshold drop (HD_THRESH overridden to 10).
module tb_match_feeder;
   import match_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [9:0]   num_main = '0;
   logic [9:0]   num_slave = '0;
   logic [9:0]   main_addr, slave_addr;
   logic [147:0] main_rdata = '0;
   logic [147:0] slave_rdata = '0;
   logic         core_clear, core_en;
   logic [147:0] core_main, core_slave;
   logic [9:0]   core_index;
   logic [19:0]  core_coor;
   logic [7:0]   core_min_hd;
   logic         core_done;
   logic         res_valid;
   logic         res_ready = 1'b1;
   logic [67:0]  res_data;
   logic         busy;

   match_feeder #(.HD_THRESH(8'd10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .num_main(num_main), .num_slave(num_slave),
      .main_addr(main_addr), .main_rdata(main_rdata),
      .slave_addr(slave_addr), .slave_rdata(slave_rdata),
      .core_clear(core_clear), .core_en(core_en),
      .core_main(core_main), .core_slave(core_slave),
      .core_index(core_index), .core_coor(core_coor),
      .core_min_hd(core_min_hd), .core_done(core_done),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [127:0] ones(input int n);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < n && i < 128; i++) r[i] = 1'b1;
      return r;
   endfunction

   // Synchronous-read descriptor memories
   logic [147:0] main_mem  [0:1023];
   logic [147:0] slave_mem [0:1023];
   always @(posedge clk) begin
      main_rdata  <= main_mem[main_addr];
      slave_rdata <= slave_mem[slave_addr];
   end

   // Matcher core: first strictly-smaller distance wins; done 4 cycles after the last core_en
   logic       en_d;
   logic [2:0] dsr;
   logic [9:0] sidx;
   logic [7:0] hd_now;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_d <= 1'b0; dsr <= '0; sidx <= '0;
         core_min_hd <= 8'hFF; core_index <= '0; core_coor <= '0;
      end else begin
         en_d <= core_en;
         dsr  <= {dsr[1:0], en_d & ~core_en};
         if (core_clear) begin
            core_min_hd <= 8'hFF;
            sidx        <= '0;
         end else if (core_en) begin
            hd_now = 8'($countones(core_main[127:0] ^ core_slave[127:0]));
            if (hd_now < core_min_hd) begin
               core_min_hd <= hd_now;
               core_index  <= sidx;
               core_coor   <= core_slave[147:128];
            end
            sidx <= sidx + 10'd1;
         end
      end
   end
   assign core_done = dsr[2];

   // Burst length, clear-to-enable gap and core_main stability monitor
   int           blen = 0;
   int           exp_ns = 0;
   logic         prev_en = 1'b0;
   logic [147:0] clr_main = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         blen = 0;
         prev_en = 1'b0;
      end else begin
         if (core_clear) clr_main = core_main;
         if (core_en) begin
            if (!prev_en) check("en_after_clear", core_clear, 0);
            blen++;
         end else if (prev_en) begin
            check("burst_len", blen, exp_ns);
            blen = 0;
         end
         if (core_done) check("core_main_hold", core_main, clr_main);
         prev_en = core_en;
      end
   end

   typedef struct packed {
      logic [9:0]      nm;
      logic [9:0]      ns;
      logic [2:0][7:0] k;     // ones-count of each Main descriptor
      logic [2:0][9:0] idx;   // expected best Slave index
      logic [2:0][7:0] hd;    // expected distance
      logic            stall;
      logic            pulse;
   } vec_t;

   function automatic vec_t mk(input int nm, ns, k0, k1, k2, i0, i1, i2, h0, h1, h2,
                               input bit st, pu);
      vec_t v;
      v.nm = 10'(nm); v.ns = 10'(ns);
      v.k[0] = 8'(k0); v.k[1] = 8'(k1); v.k[2] = 8'(k2);
      v.idx[0] = 10'(i0); v.idx[1] = 10'(i1); v.idx[2] = 10'(i2);
      v.hd[0] = 8'(h0); v.hd[1] = 8'(h1); v.hd[2] = 8'(h2);
      v.stall = st; v.pulse = pu;
      return v;
   endfunction

   vec_t vecs [6];

   task automatic run_case(input vec_t v, input string tag);
      logic [67:0] exp_d [3];
      logic [67:0] hold;
      int          nexp, nres, t2;
      logic        done, prevv, stable;
      for (int m = 0; m < 3; m++)
         main_mem[m] = {20'(32'h100 + m), ones(int'(v.k[m]))};
      exp_ns = int'(v.ns);
      nexp = 0;
      for (int m = 0; m < int'(v.nm); m++) begin
`ifdef MATCH_THRESH_EN
         if (v.hd[m] > 8'd10) continue;
`endif
         exp_d[nexp] = {10'(m), 20'(32'h100 + m), v.idx[m],
                        20'(32'h200 + int'(v.idx[m])), v.hd[m]};
         nexp++;
      end
      res_ready = !v.stall;
      @(negedge clk);
      num_main = v.nm; num_slave = v.ns; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"}, busy, 1);
      @(negedge clk);
      check({tag, "_clear_early"}, core_clear, 0);
      @(negedge clk);
      check({tag, "_start_to_clear"}, core_clear, 1);
      nres = 0; t2 = -1; done = 1'b0; prevv = 1'b0;
      for (int t = 0; t < 3000 && !done; t++) begin
         if (t > 0 && core_clear && t2 < 0) t2 = t;
         if (res_valid) begin
            if (!res_ready) begin
               hold = res_data;
               stable = 1'b1;
               for (int j = 0; j < 20; j++) begin
                  @(negedge clk);
                  if (res_valid !== 1'b1 || res_data !== hold || core_clear !== 1'b0) stable = 1'b0;
               end
               check({tag, "_stall_stable"}, stable, 1);
               res_ready = 1'b1;
            end
            if (nres < nexp) check($sformatf("%s_res%0d", tag, nres), res_data, exp_d[nres]);
            else check({tag, "_extra_result"}, 1, 0);
            nres++;
         end
         start = v.pulse && (t == 10);
         prevv = res_valid;
         @(negedge clk);
         done = !busy;
      end
      start = 1'b0;
      if (!done) check({tag, "_timeout"}, 0, 1);
      check({tag, "_result_count"}, nres, nexp);
      check({tag, "_busy_fall"}, prevv, 1);
      if (!v.stall && v.nm > 10'd1) check({tag, "_clear_period"}, t2, int'(v.ns) + 8);
   endtask

   task automatic drop_start(input int nm, ns, input string tag);
      logic seen;
      @(negedge clk);
      num_main = 10'(nm); num_slave = 10'(ns); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int j = 0; j < 12; j++) begin
         if (busy || core_en || core_clear || res_valid) seen = 1'b1;
         @(negedge clk);
      end
      check(tag, seen, 0);
   endtask

   initial begin
      for (int s = 0; s < 1024; s++)
         slave_mem[s] = {20'(32'h200 + s), ones(8 * s)};
      for (int m = 0; m < 1024; m++)
         main_mem[m] = '0;

      vecs[0] = mk(3, 5,    24, 9, 34,   3, 1, 4,   0, 1, 2,   0, 0);
      vecs[1] = mk(2, 4,    3, 26, 0,    0, 3, 0,   3, 2, 0,   1, 0);
      vecs[2] = mk(3, 2,    13, 48, 18,  1, 1, 1,   5, 40, 10, 0, 0);
      vecs[3] = mk(1, 1,    5, 0, 0,     0, 0, 0,   5, 0, 0,   0, 0);
      vecs[4] = mk(2, 16,   127, 64, 0,  15, 8, 0,  7, 0, 0,   0, 1);
      vecs[5] = mk(1, 1023, 128, 0, 0,   16, 0, 0,  0, 0, 0,   0, 0);

      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_core_en", core_en, 0);
      check("rst_core_clear", core_clear, 0);
      check("rst_main_addr", main_addr, 0);
      check("rst_slave_addr", slave_addr, 0);
      check("rst_res_data", res_data, 0);
      check("rst_core_main", core_main, 0);
      check("rst_core_slave", core_slave, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      drop_start(0, 5, "drop_num_main0");
      drop_start(3, 0, "drop_num_slave0");

      for (int i = 0; i < 6; i++) run_case(vecs[i], $sformatf("case%0d", i));

      // Reset in the middle of a Slave burst, then a clean rerun from Main 0
      main_mem[0] = {20'h100, ones(24)};
      exp_ns = 16;
      @(negedge clk);
      num_main = 10'd3; num_slave = 10'd16; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int w = 0; w < 20 && !core_en; w++) @(negedge clk);
      check("midrst_reach_stream", core_en, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_core_en", core_en, 0);
      check("midrst_busy", busy, 0);
      check("midrst_res_valid", res_valid, 0);
      check("midrst_core_clear", core_clear, 0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      run_case(vecs[0], "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
